// File: rtl/slf_video_pkg.sv
`default_nettype none
// ============================================================================
// Module      : slf_video_pkg
// Description : Shared definitions for the sprite line buffer: default
//               geometry, scan FSM encoding and the pixel transparency test.
// Revision    : 1.0 - initial release
// ============================================================================
package slf_video_pkg;

    localparam int LINE_W_DEF     = 256;  // pixels per scanline per bank
    localparam int XW_DEF         = 9;    // x address width
    localparam int PIX_W_DEF      = 8;    // {palette bits, colour bits}
    localparam int COLOR_BITS_DEF = 4;    // colour-index field width

    typedef enum logic [1:0] {
        ST_CLEAR = 2'd0,
        ST_IDLE  = 2'd1,
        ST_SCAN  = 2'd2,
        ST_DONE  = 2'd3
    } slf_state_e;

    // Colour index 0 is the transparent pen, whatever the palette bits say.
    function automatic logic is_transparent(input logic [COLOR_BITS_DEF-1:0] color);
        return (color == '0);
    endfunction

endpackage
`default_nettype wire

// File: rtl/slf_dpram.sv
`default_nettype none
// ============================================================================
// Module      : slf_dpram
// Description : Simple dual-port RAM, 2**AW x DW, written to infer block RAM.
//               Port A : registered read (read-first) plus optional write to
//                        the same address, used for read-then-clear.
//               Port B : write only.
// Ports       : clk                        - clock
//               a_re_i/a_we_i              - port A read / write enables
//               a_addr_i/a_wdata_i         - port A address / write data
//               a_rdata_o                  - port A registered read data
//               b_we_i/b_addr_i/b_wdata_i  - port B write enable/addr/data
// Revision    : 1.0 - initial release
// ============================================================================
module slf_dpram #(
    parameter int AW = 9,
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          a_re_i,
    input  logic          a_we_i,
    input  logic [AW-1:0] a_addr_i,
    input  logic [DW-1:0] a_wdata_i,
    output logic [DW-1:0] a_rdata_o,
    input  logic          b_we_i,
    input  logic [AW-1:0] b_addr_i,
    input  logic [DW-1:0] b_wdata_i
);

    logic [DW-1:0] mem_q [2**AW];

    // No reset on the array or read register so the tools can map this onto
    // a block RAM; the owner masks a_rdata_o until it holds a real read.
    // Both ports live in one process: the owner guarantees they never target
    // the same address in the same cycle.
    always_ff @(posedge clk) begin
        if (a_re_i) begin
            a_rdata_o <= mem_q[a_addr_i];
        end
        if (a_we_i) begin
            mem_q[a_addr_i] <= a_wdata_i;
        end
        if (b_we_i) begin
            mem_q[b_addr_i] <= b_wdata_i;
        end
    end

endmodule
`default_nettype wire

// File: rtl/sprite_line_buffer.sv
`default_nettype none
// ============================================================================
// Module      : sprite_line_buffer
// Description : Ping-pong sprite line buffer. The sprite side writes the next
//               scanline into bank ~disp_bank while the video side reads the
//               current line from disp_bank at pixel rate, clearing each
//               location as it is read. Banks swap on every line_start.
// Ports       : clk, nRST              - clock, async active-low reset
//               line_start             - start-of-line pulse, swaps banks
//               pix_ce                 - pixel enable, advances readout
//               wr_en, wr_x, wr_pix    - sprite pixel write
//               rd_pix, rd_valid       - registered readout pixel / qualifier
//               disp_bank              - bank being displayed
//               ready                  - power-up clear complete
//               underrun               - sticky: line swapped before fully read
// Revision    : 1.0 - initial release
// ============================================================================
module sprite_line_buffer
    import slf_video_pkg::*;
#(
    parameter int LINE_W     = LINE_W_DEF,
    parameter int XW         = XW_DEF,
    parameter int PIX_W      = PIX_W_DEF,
    parameter int COLOR_BITS = COLOR_BITS_DEF
) (
    input  logic             clk,
    input  logic             nRST,
    input  logic             line_start,
    input  logic             pix_ce,
    input  logic             wr_en,
    input  logic [XW-1:0]    wr_x,
    input  logic [PIX_W-1:0] wr_pix,
    output logic [PIX_W-1:0] rd_pix,
    output logic             rd_valid,
    output logic             disp_bank,
    output logic             ready,
    output logic             underrun
);

    localparam int             AW      = (LINE_W > 1) ? $clog2(LINE_W) : 1;
    localparam logic [XW-1:0]  X_LAST  = XW'(LINE_W - 1);
    localparam logic [XW:0]    X_LIMIT = (XW + 1)'(LINE_W);

    slf_state_e        state_q, state_d;
    logic [XW-1:0]     x_q, x_d;
    logic [XW-1:0]     clr_q, clr_d;
    logic              disp_bank_q, disp_bank_d;
    logic              ready_q, ready_d;
    logic              underrun_q, underrun_d;
    logic              rd_valid_q, rd_valid_d;

    logic              a_re, a_we;
    logic [AW:0]       a_addr;
    logic [PIX_W-1:0]  a_rdata;
    logic              b_we;
    logic [AW:0]       b_addr;
    logic [PIX_W-1:0]  b_wdata;
    logic              wr_ok;

    // A sprite write lands only once the buffer is initialised, for an opaque
    // pen and an on-screen x; anything else is dropped without wrapping.
    assign wr_ok = wr_en & ready_q
                 & ~is_transparent(wr_pix[COLOR_BITS-1:0])
                 & ({1'b0, wr_x} < X_LIMIT);

    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            state_q     <= ST_CLEAR;
            x_q         <= '0;
            clr_q       <= '0;
            disp_bank_q <= 1'b0;
            ready_q     <= 1'b0;
            underrun_q  <= 1'b0;
            rd_valid_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            x_q         <= x_d;
            clr_q       <= clr_d;
            disp_bank_q <= disp_bank_d;
            ready_q     <= ready_d;
            underrun_q  <= underrun_d;
            rd_valid_q  <= rd_valid_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        x_d         = x_q;
        clr_d       = clr_q;
        disp_bank_d = disp_bank_q;
        ready_d     = ready_q;
        underrun_d  = underrun_q;
        rd_valid_d  = rd_valid_q;
        a_re        = 1'b0;
        a_we        = 1'b0;
        a_addr      = {disp_bank_q, x_q[AW-1:0]};
        b_we        = 1'b0;
        b_addr      = {~disp_bank_q, wr_x[AW-1:0]};
        b_wdata     = wr_pix;

        case (state_q)
            ST_CLEAR: begin
                // Both ports sweep the same offset, one per bank, so the
                // whole RAM is zeroed in LINE_W cycles.
                a_we       = 1'b1;
                a_addr     = {1'b0, clr_q[AW-1:0]};
                b_we       = 1'b1;
                b_addr     = {1'b1, clr_q[AW-1:0]};
                b_wdata    = '0;
                rd_valid_d = 1'b0;
                if (clr_q == X_LAST) begin
                    clr_d   = '0;
                    ready_d = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    clr_d = clr_q + 1'b1;
                end
            end

            ST_IDLE, ST_DONE: begin
                // The final pixel of a line stays visible for the first DONE
                // cycle (it was registered on the read), then goes blank.
                rd_valid_d = 1'b0;
                if (line_start) begin
                    disp_bank_d = ~disp_bank_q;
                    x_d         = '0;
                    state_d     = ST_SCAN;
                end
            end

            ST_SCAN: begin
                if (line_start) begin
                    // Early swap: the rest of this bank is left stale.
                    // pix_ce in the same cycle is deliberately dropped.
                    underrun_d  = 1'b1;
                    disp_bank_d = ~disp_bank_q;
                    x_d         = '0;
                    rd_valid_d  = 1'b0;
                end else if (pix_ce) begin
                    a_re       = 1'b1;
                    a_we       = 1'b1;   // read-first RAM: clear behind the read
                    rd_valid_d = 1'b1;
                    if (x_q == X_LAST) begin
                        x_d     = '0;
                        state_d = ST_DONE;
                    end else begin
                        x_d = x_q + 1'b1;
                    end
                end
            end

            default: begin
                state_d = ST_CLEAR;
            end
        endcase

        // Write port targets the back bank only, so it never meets port A.
        if (state_q != ST_CLEAR && wr_ok) begin
            b_we    = 1'b1;
            b_addr  = {~disp_bank_q, wr_x[AW-1:0]};
            b_wdata = wr_pix;
        end
    end

    slf_dpram #(
        .AW (AW + 1),
        .DW (PIX_W)
    ) u_ram (
        .clk       (clk),
        .a_re_i    (a_re),
        .a_we_i    (a_we),
        .a_addr_i  (a_addr),
        .a_wdata_i ({PIX_W{1'b0}}),
        .a_rdata_o (a_rdata),
        .b_we_i    (b_we),
        .b_addr_i  (b_addr),
        .b_wdata_i (b_wdata)
    );

    // RAM read data is only meaningful after a read; mask it otherwise.
    assign rd_pix    = rd_valid_q ? a_rdata : '0;
    assign rd_valid  = rd_valid_q;
    assign disp_bank = disp_bank_q;
    assign ready     = ready_q;
    assign underrun  = underrun_q;

endmodule
`default_nettype wire

// File: tb/tb_sprite_line_buffer.sv
`default_nettype none
// ============================================================================
// Module      : tb_sprite_line_buffer
// Description : Self-checking bench for sprite_line_buffer with a behavioural
//               two-bank line model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sprite_line_buffer;

    localparam int LINE_W = 256;

    logic       clk = 1'b0;
    logic       nRST = 1'b0;
    logic       line_start = 1'b0;
    logic       pix_ce = 1'b0;
    logic       wr_en = 1'b0;
    logic [8:0] wr_x = '0;
    logic [7:0] wr_pix = '0;
    logic [7:0] rd_pix;
    logic       rd_valid, disp_bank, ready, underrun;

    int errors = 0;
    int checks = 0;

    sprite_line_buffer dut (
        .clk        (clk),
        .nRST       (nRST),
        .line_start (line_start),
        .pix_ce     (pix_ce),
        .wr_en      (wr_en),
        .wr_x       (wr_x),
        .wr_pix     (wr_pix),
        .rd_pix     (rd_pix),
        .rd_valid   (rd_valid),
        .disp_bank  (disp_bank),
        .ready      (ready),
        .underrun   (underrun)
    );

    always #5 clk = ~clk;

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation did not finish, got timeout want finish");
        $fatal(1, "watchdog");
    end

    // ---------------- behavioural model ----------------
    logic [7:0] m_mem [2][LINE_W];
    bit         m_bank, m_scan, m_ready, m_under, m_valid;
    int         m_x, m_clr;
    logic [7:0] m_pix;

    logic [7:0] got [LINE_W];
    logic       gotv [LINE_W];
    logic [7:0] exp_line [LINE_W];

    task automatic model_reset();
        m_ready = 0; m_clr = 0; m_bank = 0; m_scan = 0;
        m_under = 0; m_valid = 0; m_pix = '0; m_x = 0;
    endtask

    task automatic model_step();
        if (!m_ready) begin
            m_clr++;
            if (m_clr == LINE_W) begin
                m_ready = 1;
                for (int b = 0; b < 2; b++)
                    for (int i = 0; i < LINE_W; i++) m_mem[b][i] = '0;
            end
        end else begin
            if (wr_en && wr_pix[3:0] != 4'd0 && wr_x < 9'(LINE_W))
                m_mem[!m_bank][wr_x[7:0]] = wr_pix;
            if (line_start) begin
                if (m_scan) m_under = 1;
                m_bank  = !m_bank;
                m_x     = 0;
                m_scan  = 1;
                m_valid = 0;
            end else if (m_scan && pix_ce) begin
                m_pix = m_mem[m_bank][m_x];
                m_mem[m_bank][m_x] = '0;
                m_valid = 1;
                m_x++;
                if (m_x == LINE_W) m_scan = 0;
            end else if (!m_scan) begin
                m_valid = 0;
            end
        end
    endtask

    function automatic logic [7:0] m_out();
        return m_valid ? m_pix : 8'h00;
    endfunction

    // One clock: model consumes the current inputs, DUT clocks, strobes drop.
    task automatic cycle();
        model_step();
        @(posedge clk);
        #1;
        line_start = 1'b0;
        pix_ce     = 1'b0;
        wr_en      = 1'b0;
    endtask

    task automatic rand_write();
        wr_en  = 1'($urandom_range(0, 1));
        wr_x   = 9'($urandom_range(0, 299));
        wr_pix = 8'($urandom);
    endtask

    task automatic read_line(input bit with_writes);
        for (int i = 0; i < LINE_W; i++) begin
            int gap;
            gap = $urandom_range(0, 2);
            for (int g = 0; g < gap; g++) begin
                if (with_writes) rand_write();
                cycle();
            end
            if (with_writes) rand_write();
            pix_ce = 1'b1;
            cycle();
            got[i]      = rd_pix;
            gotv[i]     = rd_valid;
            exp_line[i] = m_out();
        end
    endtask

    task automatic wait_ready(output int cnt, output int vbad);
        cnt = 0; vbad = 0;
        while (!ready && cnt < 400) begin
            if (cnt == 5) begin
                wr_en = 1'b1; wr_x = 9'd3; wr_pix = 8'h11;
            end
            cycle();
            cnt++;
            if (rd_valid !== 1'b0) vbad++;
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        int cnt, vbad;
        nRST = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (rd_pix !== 8'h00)   begin errors++; $display("FAIL reset_rd_pix: got %h want 00", rd_pix); end
        checks++; if (rd_valid !== 1'b0)  begin errors++; $display("FAIL reset_rd_valid: got %b want 0", rd_valid); end
        checks++; if (disp_bank !== 1'b0) begin errors++; $display("FAIL reset_disp_bank: got %b want 0", disp_bank); end
        checks++; if (ready !== 1'b0)     begin errors++; $display("FAIL reset_ready: got %b want 0", ready); end
        checks++; if (underrun !== 1'b0)  begin errors++; $display("FAIL reset_underrun: got %b want 0", underrun); end
        model_reset();
        nRST = 1'b1;
        wait_ready(cnt, vbad);
        checks++; if (cnt != LINE_W) begin errors++; $display("FAIL clear_length: got %0d cycles want %0d", cnt, LINE_W); end
        checks++; if (vbad != 0)     begin errors++; $display("FAIL clear_rd_valid: got %0d valid cycles want 0", vbad); end
        checks++; if (ready !== 1'(m_ready)) begin errors++; $display("FAIL clear_ready: got %b want %b", ready, m_ready); end
    endtask

    task automatic test_single_pixel();
        int mism, nz;
        wr_en = 1'b1; wr_x = 9'd10; wr_pix = 8'h35;
        cycle();
        line_start = 1'b1;
        cycle();
        checks++; if (disp_bank !== 1'b1) begin errors++; $display("FAIL single_bank: got %b want 1", disp_bank); end
        read_line(1'b0);
        mism = 0; nz = 0;
        for (int i = 0; i < LINE_W; i++) begin
            if (got[i] !== exp_line[i] || gotv[i] !== 1'b1) mism++;
            if (got[i] != 8'h00) nz++;
        end
        checks++; if (mism != 0)       begin errors++; $display("FAIL single_line: got %0d mismatching pixels want 0", mism); end
        checks++; if (got[10] !== 8'h35) begin errors++; $display("FAIL single_x10: got %h want 35", got[10]); end
        checks++; if (got[3] !== 8'h00)  begin errors++; $display("FAIL clear_write_ignored_x3: got %h want 00", got[3]); end
        checks++; if (nz != 1)         begin errors++; $display("FAIL single_nonzero: got %0d want 1", nz); end
    endtask

    task automatic test_overlap();
        int mism, nz;
        logic [7:0] seq [4];
        logic [8:0] xs [4];
        seq = '{8'h12, 8'h40, 8'h27, 8'h55};
        xs  = '{9'd20, 9'd20, 9'd20, 9'd300};
        for (int k = 0; k < 4; k++) begin
            wr_en = 1'b1; wr_x = xs[k]; wr_pix = seq[k];
            cycle();
        end
        line_start = 1'b1;
        cycle();
        read_line(1'b0);
        mism = 0; nz = 0;
        for (int i = 0; i < LINE_W; i++) begin
            if (got[i] !== exp_line[i]) mism++;
            if (got[i] != 8'h00) nz++;
        end
        checks++; if (got[20] !== 8'h27) begin errors++; $display("FAIL overlap_x20: got %h want 27", got[20]); end
        checks++; if (nz != 1)           begin errors++; $display("FAIL overlap_nonzero: got %0d want 1", nz); end
        checks++; if (mism != 0)         begin errors++; $display("FAIL overlap_line: got %0d mismatching want 0", mism); end
        // Bank 1 again after two swaps: must have been cleared by its readout.
        line_start = 1'b1;
        cycle();
        checks++; if (disp_bank !== 1'b1) begin errors++; $display("FAIL reread_bank: got %b want 1", disp_bank); end
        read_line(1'b0);
        nz = 0;
        for (int i = 0; i < LINE_W; i++) if (got[i] !== 8'h00) nz++;
        checks++; if (nz != 0) begin errors++; $display("FAIL reread_cleared: got %0d nonzero want 0", nz); end
    endtask

    task automatic test_random();
        int mism;
        for (int l = 0; l < 3; l++) begin
            for (int k = 0; k < 40; k++) begin
                rand_write();
                cycle();
            end
            line_start = 1'b1;
            cycle();
            read_line(1'b1);
            mism = 0;
            for (int i = 0; i < LINE_W; i++)
                if (got[i] !== exp_line[i] || gotv[i] !== 1'b1) mism++;
            checks++; if (mism != 0) begin errors++; $display("FAIL random_line%0d: got %0d mismatching want 0", l, mism); end
        end
        checks++; if (underrun !== 1'b0) begin errors++; $display("FAIL random_underrun: got %b want 0", underrun); end
    endtask

    task automatic test_underrun();
        logic prev;
        int mism;
        line_start = 1'b1;
        cycle();
        for (int i = 0; i < 100; i++) begin
            if (i == 0) begin wr_en = 1'b1; wr_x = 9'd0; wr_pix = 8'h5A; end
            else rand_write();
            pix_ce = 1'b1;
            cycle();
        end
        checks++; if (underrun !== 1'b0) begin errors++; $display("FAIL underrun_early: got %b want 0", underrun); end
        prev = disp_bank;
        line_start = 1'b1;
        cycle();
        checks++; if (underrun !== 1'b1)  begin errors++; $display("FAIL underrun_set: got %b want 1", underrun); end
        checks++; if (disp_bank !== ~prev) begin errors++; $display("FAIL underrun_bank: got %b want %b", disp_bank, ~prev); end
        pix_ce = 1'b1;
        cycle();
        checks++; if (rd_pix !== 8'h5A || rd_pix !== m_out()) begin errors++; $display("FAIL underrun_x0: got %h want 5a", rd_pix); end
        mism = 0;
        for (int i = 1; i < LINE_W; i++) begin
            pix_ce = 1'b1;
            cycle();
            if (rd_pix !== m_out() || rd_valid !== 1'b1) mism++;
        end
        checks++; if (mism != 0)        begin errors++; $display("FAIL underrun_rest: got %0d mismatching want 0", mism); end
        checks++; if (underrun !== 1'b1) begin errors++; $display("FAIL underrun_sticky: got %b want 1", underrun); end
        // Interrupted bank comes back with its unread pixels still stale.
        line_start = 1'b1;
        cycle();
        read_line(1'b0);
        mism = 0;
        for (int i = 0; i < LINE_W; i++) if (got[i] !== exp_line[i]) mism++;
        checks++; if (mism != 0) begin errors++; $display("FAIL stale_line: got %0d mismatching want 0", mism); end
    endtask

    task automatic test_collision();
        logic prev;
        int cnt, vbad, nz;
        line_start = 1'b1;
        cycle();
        for (int i = 0; i < 10; i++) begin
            if (i == 0) begin wr_en = 1'b1; wr_x = 9'd0; wr_pix = 8'h6C; end
            pix_ce = 1'b1;
            cycle();
        end
        prev = disp_bank;
        line_start = 1'b1; pix_ce = 1'b1;
        cycle();
        checks++; if (rd_valid !== 1'b0)   begin errors++; $display("FAIL collide_valid: got %b want 0", rd_valid); end
        checks++; if (disp_bank !== ~prev) begin errors++; $display("FAIL collide_bank: got %b want %b", disp_bank, ~prev); end
        pix_ce = 1'b1;
        cycle();
        checks++; if (rd_pix !== 8'h6C || rd_valid !== 1'b1) begin errors++; $display("FAIL collide_x0: got %h/%b want 6c/1", rd_pix, rd_valid); end
        for (int i = 0; i < 5; i++) begin pix_ce = 1'b1; cycle(); end
        // Asynchronous reset in the middle of a clock period.
        #2 nRST = 1'b0;
        #1;
        checks++; if (rd_pix !== 8'h00)   begin errors++; $display("FAIL async_rd_pix: got %h want 00", rd_pix); end
        checks++; if (rd_valid !== 1'b0)  begin errors++; $display("FAIL async_rd_valid: got %b want 0", rd_valid); end
        checks++; if (disp_bank !== 1'b0) begin errors++; $display("FAIL async_bank: got %b want 0", disp_bank); end
        checks++; if (ready !== 1'b0)     begin errors++; $display("FAIL async_ready: got %b want 0", ready); end
        checks++; if (underrun !== 1'b0)  begin errors++; $display("FAIL async_underrun: got %b want 0", underrun); end
        model_reset();
        @(posedge clk); #1;
        nRST = 1'b1;
        wait_ready(cnt, vbad);
        checks++; if (cnt != LINE_W) begin errors++; $display("FAIL reclear_length: got %0d want %0d", cnt, LINE_W); end
        line_start = 1'b1;
        cycle();
        read_line(1'b0);
        nz = 0;
        for (int i = 0; i < LINE_W; i++) if (got[i] !== 8'h00 || got[i] !== exp_line[i]) nz++;
        checks++; if (nz != 0) begin errors++; $display("FAIL reclear_zero: got %0d nonzero want 0", nz); end
    endtask

    initial begin
        test_reset();
        test_single_pixel();
        test_overlap();
        test_random();
        test_underrun();
        test_collision();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
